// File: rtl/fir_out_serializer_if.sv
// rtl/fir_out_serializer_if.sv - triple-in / serial-out port bundle for the FIR output serializer
interface fir_out_serializer_if #(
    parameter int NB = 7
);
    logic [NB-1:0] d_in_3k;
    logic [NB-1:0] d_in_3k_1;
    logic [NB-1:0] d_in_3k_2;
    logic          v_in;
    logic [NB-1:0] d_out;
    logic          v_out;
    logic          ovf;

    modport master (
        output d_in_3k,
        output d_in_3k_1,
        output d_in_3k_2,
        output v_in,
        input  d_out,
        input  v_out,
        input  ovf
    );

    modport slave (
        input  d_in_3k,
        input  d_in_3k_1,
        input  d_in_3k_2,
        input  v_in,
        output d_out,
        output v_out,
        output ovf
    );
endinterface

// File: rtl/fir_out_serializer.sv
// rtl/fir_out_serializer.sv - two-triple buffer that serializes 3-parallel FIR outputs in time order
module fir_out_serializer #(
    parameter int NB    = 7,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    fir_out_serializer_if.slave bus
);

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2
    } phase_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [NB-1:0] slot_3k   [2];
    logic [NB-1:0] slot_3k_1 [2];
    logic [NB-1:0] slot_3k_2 [2];

    logic          wp_q;
    logic          rp_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    phase_t        phase_q;
    phase_t        phase_d;

    logic [NB-1:0] d_out_q;
    logic          v_out_q;
    logic          ovf_q;

    logic          step;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic [NB-1:0] head;

    // A pop frees a slot on the same edge, so a full buffer can still accept.
    always_comb begin
        step    = (count_q != 2'd0);
        pop     = step && (phase_q == PH_2);
        push_ok = bus.v_in && ((count_q != FULL) || pop);
        drop    = bus.v_in && !push_ok;
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop};
    end

    always_comb begin
        head = slot_3k[rp_q];
        unique case (phase_q)
            PH_1:    head = slot_3k_1[rp_q];
            PH_2:    head = slot_3k_2[rp_q];
            default: head = slot_3k[rp_q];
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        if (!step) begin
            phase_d = PH_0;
        end else begin
            unique case (phase_q)
                PH_0:    phase_d = PH_1;
                PH_1:    phase_d = PH_2;
                default: phase_d = PH_0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Slot contents are don't-care after reset; only pointers and count matter.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            slot_3k[wp_q]   <= bus.d_in_3k;
            slot_3k_1[wp_q] <= bus.d_in_3k_1;
            slot_3k_2[wp_q] <= bus.d_in_3k_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            count_q <= 2'd0;
            d_out_q <= '0;
            v_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                wp_q <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            if (step) begin
                d_out_q <= head;
                v_out_q <= 1'b1;
            end else begin
                v_out_q <= 1'b0;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.d_out = d_out_q;
    assign bus.v_out = v_out_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_fir_out_serializer.sv
// tb/tb_fir_out_serializer.sv - directed table-driven bench for fir_out_serializer
module tb_fir_out_serializer;

    logic clk;
    logic rst_n;

    fir_out_serializer_if #(.NB(7)) bus ();

    fir_out_serializer #(.NB(7), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v_in;
        logic [6:0] a;
        logic [6:0] b;
        logic [6:0] c;
        logic       exp_v;
        logic [6:0] exp_d;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl [25];
    int   errors;
    int   checks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [6:0] ed, input logic eo);
        check({tag, " v_out"}, {31'd0, bus.v_out}, {31'd0, ev});
        check({tag, " d_out"}, {25'd0, bus.d_out}, {25'd0, ed});
        check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, eo});
    endtask

    task automatic drive(input logic v, input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        bus.v_in      = v;
        bus.d_in_3k   = a;
        bus.d_in_3k_1 = b;
        bus.d_in_3k_2 = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #4;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(1'b0, 7'd0, 7'd0, 7'd0);

        tbl[0]  = '{1'b1, 7'd5,  7'd125, 7'd63, 1'b0, 7'd0,   1'b0};
        tbl[1]  = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd5,   1'b0};
        tbl[2]  = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd125, 1'b0};
        tbl[3]  = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd63,  1'b0};
        tbl[4]  = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b0, 7'd63,  1'b0};
        tbl[5]  = '{1'b1, 7'd10, 7'd11,  7'd12, 1'b0, 7'd63,  1'b0};
        tbl[6]  = '{1'b1, 7'd20, 7'd21,  7'd22, 1'b1, 7'd10,  1'b0};
        tbl[7]  = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd11,  1'b0};
        tbl[8]  = '{1'b1, 7'd30, 7'd31,  7'd32, 1'b1, 7'd12,  1'b0};
        tbl[9]  = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd20,  1'b0};
        tbl[10] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd21,  1'b0};
        tbl[11] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd22,  1'b0};
        tbl[12] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd30,  1'b0};
        tbl[13] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd31,  1'b0};
        tbl[14] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd32,  1'b0};
        tbl[15] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b0, 7'd32,  1'b0};
        tbl[16] = '{1'b1, 7'd40, 7'd41,  7'd42, 1'b0, 7'd32,  1'b0};
        tbl[17] = '{1'b1, 7'd50, 7'd51,  7'd52, 1'b1, 7'd40,  1'b0};
        tbl[18] = '{1'b1, 7'd60, 7'd61,  7'd62, 1'b1, 7'd41,  1'b1};
        tbl[19] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd42,  1'b1};
        tbl[20] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd50,  1'b1};
        tbl[21] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd51,  1'b1};
        tbl[22] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b1, 7'd52,  1'b1};
        tbl[23] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b0, 7'd52,  1'b1};
        tbl[24] = '{1'b0, 7'd0,  7'd0,   7'd0,  1'b0, 7'd52,  1'b1};

        // power-on reset state
        #3;
        check_out("por", 1'b0, 7'd0, 1'b0);
        do_reset();

        // line rate: ten triples, one every 3 cycles
        for (int cyc = 0; cyc < 32; cyc++) begin
            if ((cyc % 3 == 0) && (cyc < 30)) begin
                drive(1'b1, 7'(cyc), 7'(cyc + 1), 7'(cyc + 2));
            end else begin
                drive(1'b0, 7'd0, 7'd0, 7'd0);
            end
            step();
            if (cyc >= 1 && cyc <= 30) begin
                check_out($sformatf("rate[%0d]", cyc), 1'b1, 7'(cyc - 1), 1'b0);
            end else if (cyc == 0) begin
                check_out("rate[0]", 1'b0, 7'd0, 1'b0);
            end else begin
                check_out("rate[31]", 1'b0, 7'd29, 1'b0);
            end
        end

        // single triple, push/pop collision, overflow
        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].v_in, tbl[i].a, tbl[i].b, tbl[i].c);
            step();
            check_out($sformatf("tbl[%0d]", i), tbl[i].exp_v, tbl[i].exp_d, tbl[i].exp_ovf);
        end
        drive(1'b0, 7'd0, 7'd0, 7'd0);

        // asynchronous reset between edges clears outputs immediately
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 7'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_out($sformatf("post_rst[%0d]", i), 1'b0, 7'd0, 1'b0);
        end

        // mid-stream reset during the second sample of a triple
        drive(1'b1, 7'd1, 7'd2, 7'd3);
        step();
        check_out("mid push", 1'b0, 7'd0, 1'b0);
        drive(1'b0, 7'd0, 7'd0, 7'd0);
        step();
        check_out("mid s0", 1'b1, 7'd1, 1'b0);
        step();
        check_out("mid s1", 1'b1, 7'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("mid rst", 1'b0, 7'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_out($sformatf("mid idle[%0d]", i), 1'b0, 7'd0, 1'b0);
        end
        drive(1'b1, 7'd7, 7'd8, 7'd9);
        step();
        check_out("fresh push", 1'b0, 7'd0, 1'b0);
        drive(1'b0, 7'd0, 7'd0, 7'd0);
        step();
        check_out("fresh s0", 1'b1, 7'd7, 1'b0);
        step();
        check_out("fresh s1", 1'b1, 7'd8, 1'b0);
        step();
        check_out("fresh s2", 1'b1, 7'd9, 1'b0);
        step();
        check_out("fresh idle", 1'b0, 7'd9, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
